fb_scan_arbiter: RTL



---
 rtl/vga_fb_pkg.sv | 15 +
 rtl/fb_rr_arb2.sv | 33 +++
 rtl/fb_scan_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: frame-buffer geometry and the port IDs used by the scan arbiter.
//   FB_W x FB_H grayscale pixels of PIX_W bits, addressed linearly with ADDR_W bits.
//   port_e identifies which request port owns an outstanding read.
package vga_fb_pkg;
    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int PIX_W    = 8;
    localparam int ADDR_W   = 17;
    localparam int FB_WORDS = FB_W * FB_H;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;
endpackage

// File: rtl/fb_rr_arb2.sv
// fb_rr_arb2: two-way round-robin arbiter with a blocking input.
//   clk, reset  : clock, synchronous active-high reset
//   req[1:0]    : request from port A (bit 0) and port B (bit 1)
//   block       : suppresses all grants this cycle (scan-out slot or reset)
//   gnt[1:0]    : one-hot grant, A in bit 0
//   last_grant  : port that won the most recent grant; resets to PORT_B so A wins the first tie
module fb_rr_arb2
    import vga_fb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       block,
    output logic [1:0] gnt,
    output port_e      last_grant
);
    port_e last_q, last_d;

    // A tie goes to the port that did not win last time; a lone request always wins.
    assign gnt[0] = ~block & req[0] & (~req[1] | (last_q == PORT_B));
    assign gnt[1] = ~block & req[1] & (~req[0] | (last_q == PORT_A));

    assign last_d     = gnt[0] ? PORT_A : gnt[1] ? PORT_B : last_q;
    assign last_grant = last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter: shares the single frame-buffer BRAM port between VGA scan-out and two request ports.
//   clk, reset              : 100 MHz clock, synchronous active-high reset
//   p_tick, video_on, x, y  : pixel tick, active-video flag and raster counters from vga_sync
//   a_* / b_*               : valid/ready request ports (we, addr, wdata) and read-response pulses
//   rsp_rdata               : read data shared by both ports (at most one response per cycle)
//   mem_*                   : BRAM port; mem_rdata arrives one cycle after mem_en
//   pix_data                : scan-out pixel, updated two cycles after the fetch slot
module fb_scan_arbiter
    import vga_fb_pkg::*;
#(
    parameter int FB_W   = vga_fb_pkg::FB_W,
    parameter int FB_H   = vga_fb_pkg::FB_H,
    parameter int PIX_W  = vga_fb_pkg::PIX_W,
    parameter int ADDR_W = vga_fb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              a_valid,
    input  logic              b_valid,
    output logic              a_ready,
    output logic              b_ready,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [PIX_W-1:0]  a_wdata,
    input  logic [PIX_W-1:0]  b_wdata,
    output logic              a_rsp_valid,
    output logic              b_rsp_valid,
    output logic [PIX_W-1:0]  rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pix_data
);
    localparam int WORDS = FB_W * FB_H;

    logic              p_tick_q, disp_q, blank_q;
    logic              disp_slot, blk, scan, grant, req_we, in_range;
    logic [1:0]        gnt;
    port_e             last_grant;
    logic [ADDR_W-1:0] x_half, y_half, scan_addr, req_addr;
    logic [PIX_W-1:0]  req_wdata;
    logic              rd_vld_q, rd_vld_d, rd_ok_q, rd_ok_d;
    port_e             rd_port_q, rd_port_d;
    logic              a_rsp_q, a_rsp_d, b_rsp_q, b_rsp_d;
    logic [PIX_W-1:0]  rsp_q, rsp_d, pix_q, pix_d;

    // The fetch slot is the cycle after the pixel tick, so it sits at a fixed phase of every pixel period.
    assign disp_slot = p_tick_q & video_on;
    assign blk       = disp_slot | reset;
    assign scan      = disp_slot & ~reset;

    fb_rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        ({b_valid, a_valid}),
        .block      (blk),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    // Ready looks only at the other port's valid, so no port sees its own valid reflected in its ready.
    assign a_ready = ~blk & (~b_valid | (last_grant == PORT_B));
    assign b_ready = ~blk & (~a_valid | (last_grant == PORT_A));

    // (y/2)*320 + x/2 using shifts: 320 = 256 + 64.
    assign x_half    = ADDR_W'(x >> 1);
    assign y_half    = ADDR_W'(y >> 1);
    assign scan_addr = (y_half << 8) + (y_half << 6) + x_half;

    assign grant     = |gnt;
    assign req_addr  = gnt[1] ? b_addr : a_addr;
    assign req_we    = gnt[1] ? b_we : a_we;
    assign req_wdata = gnt[1] ? b_wdata : a_wdata;
    assign in_range  = req_addr < ADDR_W'(WORDS);

    // Out-of-range requests are accepted but never touch the BRAM.
    assign mem_en    = scan | (grant & in_range);
    assign mem_we    = grant & req_we & in_range;
    assign mem_addr  = scan ? scan_addr : grant ? req_addr : '0;
    assign mem_wdata = mem_we ? req_wdata : '0;

    // Tag each accepted read so its data, one cycle later, is steered to the right port.
    assign rd_vld_d  = grant & ~req_we;
    assign rd_port_d = gnt[1] ? PORT_B : PORT_A;
    assign rd_ok_d   = in_range;

    assign a_rsp_d = rd_vld_q & (rd_port_q == PORT_A);
    assign b_rsp_d = rd_vld_q & (rd_port_q == PORT_B);
    assign rsp_d   = (rd_vld_q & rd_ok_q) ? mem_rdata : '0;

    // A slot fetched during blanking blanks the pixel; otherwise it holds between fetches.
    assign pix_d = disp_q ? mem_rdata : blank_q ? '0 : pix_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_tick_q  <= 1'b0;
            disp_q    <= 1'b0;
            blank_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_ok_q   <= 1'b0;
            rd_port_q <= PORT_A;
            a_rsp_q   <= 1'b0;
            b_rsp_q   <= 1'b0;
            rsp_q     <= '0;
            pix_q     <= '0;
        end else begin
            p_tick_q  <= p_tick;
            disp_q    <= disp_slot;
            blank_q   <= p_tick_q & ~video_on;
            rd_vld_q  <= rd_vld_d;
            rd_ok_q   <= rd_ok_d;
            rd_port_q <= rd_port_d;
            a_rsp_q   <= a_rsp_d;
            b_rsp_q   <= b_rsp_d;
            rsp_q     <= rsp_d;
            pix_q     <= pix_d;
        end
    end

    assign a_rsp_valid = a_rsp_q;
    assign b_rsp_valid = b_rsp_q;
    assign rsp_rdata   = rsp_q;
    assign pix_data    = pix_q;
endmodule
